ma_cvxif_offload_queue: RTL

Sits between the CVA6 CV-X-IF coprocessor port and the matrix accelerator core. It decodes offloaded custom-0 instructions and accepts or rejects them. Accepted instructions wait in an in-order queue until CVA6 commits or kills them. Committed instructions go to the accelerator in program order, and accelerator completions return to CVA6 as tagged writeback results.

---
 rtl/ma_cvxif_offload_queue.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ma_cvxif_offload_queue.sv
// CV-X-IF offload queue: claims custom-0 instructions, holds them in order until
// commit/kill, dispatches committed ones to the accelerator and returns tagged results.
module ma_cvxif_offload_queue #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ID_WIDTH = 3,
   parameter int unsigned DEPTH    = 4,
   parameter logic [6:0]  OPCODE   = 7'b0001011
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                issue_valid_i,
   output logic                issue_ready_o,
   input  logic [31:0]         issue_instr_i,
   input  logic [ID_WIDTH-1:0] issue_id_i,
   input  logic [XLEN-1:0]     issue_rs1_i,
   input  logic [XLEN-1:0]     issue_rs2_i,
   input  logic [1:0]          issue_rs_valid_i,
   output logic                issue_accept_o,
   output logic                issue_writeback_o,
   input  logic                commit_valid_i,
   input  logic [ID_WIDTH-1:0] commit_id_i,
   input  logic                commit_kill_i,
   output logic                acc_req_valid_o,
   input  logic                acc_req_ready_i,
   output logic [31:0]         acc_req_instr_o,
   output logic [XLEN-1:0]     acc_req_rs1_o,
   output logic [XLEN-1:0]     acc_req_rs2_o,
   input  logic                acc_rsp_valid_i,
   output logic                acc_rsp_ready_o,
   input  logic [XLEN-1:0]     acc_rsp_data_i,
   output logic                result_valid_o,
   input  logic                result_ready_i,
   output logic [ID_WIDTH-1:0] result_id_o,
   output logic [XLEN-1:0]     result_data_o,
   output logic                result_we_o
);
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned PTR_W1 = PTR_W + 1;

   typedef enum logic [1:0] {E_FREE, E_ISSUED, E_COMMITTED, E_KILLED} entry_state_e;

   typedef struct packed {
      logic [ID_WIDTH-1:0] id;
      logic                we;
      logic [31:0]         instr;
      logic [XLEN-1:0]     rs1;
      logic [XLEN-1:0]     rs2;
   } entry_t;

   typedef struct packed {
      logic [ID_WIDTH-1:0] id;
      logic                we;
   } tag_t;

   entry_state_e        q_state [DEPTH];
   entry_t              q_data  [DEPTH];
   logic [PTR_W:0]      q_wr, q_rd;
   tag_t                tag_mem [DEPTH];
   logic [PTR_W:0]      tag_wr, tag_rd;

   logic                q_full, tag_full, tag_empty;
   logic [PTR_W-1:0]    head;
   logic                match, operands_ok, enq;
   logic                iss_found;
   logic [PTR_W-1:0]    iss_idx;
   logic                commit_old, commit_new;
   logic                disp, pop, rsp_hs, rsp_take;
   entry_state_e        commit_state;

   assign head      = q_rd[PTR_W-1:0];
   assign q_full    = (q_wr[PTR_W] != q_rd[PTR_W]) && (q_wr[PTR_W-1:0] == q_rd[PTR_W-1:0]);
   assign tag_full  = (tag_wr[PTR_W] != tag_rd[PTR_W]) && (tag_wr[PTR_W-1:0] == tag_rd[PTR_W-1:0]);
   assign tag_empty = (tag_wr == tag_rd);

   // Issue decode: claim custom-0, stall on full queue or missing operands
   always_comb begin
      issue_ready_o     = 1'b1;
      issue_accept_o    = 1'b0;
      issue_writeback_o = 1'b0;
      match             = (issue_instr_i[6:0] == OPCODE);
      operands_ok       = (issue_rs_valid_i == 2'b11);
      if (match) begin
         issue_ready_o = !q_full && operands_ok;
         issue_accept_o = !q_full && operands_ok;
         issue_writeback_o = !q_full && operands_ok && issue_instr_i[14];
      end
      enq = issue_valid_i && issue_accept_o;
   end

   // Oldest ISSUED entry, scanning from the head in program order
   always_comb begin
      iss_found = 1'b0;
      iss_idx   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!iss_found && q_state[head + PTR_W'(i)] == E_ISSUED) begin
            iss_found = 1'b1;
            iss_idx   = head + PTR_W'(i);
         end
      end
   end

   always_comb begin
      commit_old   = commit_valid_i && iss_found && (q_data[iss_idx].id == commit_id_i);
      commit_new   = commit_valid_i && !iss_found && enq && (issue_id_i == commit_id_i);
      commit_state = commit_kill_i ? E_KILLED : E_COMMITTED;
   end

   assign acc_req_valid_o = (q_state[head] == E_COMMITTED) && !tag_full;
   assign acc_req_instr_o = q_data[head].instr;
   assign acc_req_rs1_o   = q_data[head].rs1;
   assign acc_req_rs2_o   = q_data[head].rs2;
   assign disp            = acc_req_valid_o && acc_req_ready_i;
   assign pop             = disp || (q_state[head] == E_KILLED);

   assign acc_rsp_ready_o = !result_valid_o || result_ready_i;
   assign rsp_hs          = acc_rsp_valid_i && acc_rsp_ready_o;
   assign rsp_take        = rsp_hs && !tag_empty;

   // Offload queue entries and pointers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_state <= '{default: E_FREE};
         q_data  <= '{default: '0};
         q_wr    <= '0;
         q_rd    <= '0;
      end else begin
         if (commit_old) q_state[iss_idx] <= commit_state;
         if (pop) begin
            q_state[head] <= E_FREE;
            q_rd          <= q_rd + PTR_W1'(1);
         end
         if (enq) begin
            q_state[q_wr[PTR_W-1:0]] <= commit_new ? commit_state : E_ISSUED;
            q_data[q_wr[PTR_W-1:0]]  <= '{id: issue_id_i, we: issue_instr_i[14], instr: issue_instr_i,
                                          rs1: issue_rs1_i, rs2: issue_rs2_i};
            q_wr                     <= q_wr + PTR_W1'(1);
         end
      end
   end

   // In-flight tags of dispatched, uncompleted instructions
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tag_mem <= '{default: '0};
         tag_wr  <= '0;
         tag_rd  <= '0;
      end else begin
         if (disp) begin
            tag_mem[tag_wr[PTR_W-1:0]] <= '{id: q_data[head].id, we: q_data[head].we};
            tag_wr                     <= tag_wr + PTR_W1'(1);
         end
         if (rsp_take) tag_rd <= tag_rd + PTR_W1'(1);
      end
   end

   // Result register toward CVA6
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         result_valid_o <= 1'b0;
         result_id_o    <= '0;
         result_data_o  <= '0;
         result_we_o    <= 1'b0;
      end else if (rsp_take) begin
         result_valid_o <= 1'b1;
         result_id_o    <= tag_mem[tag_rd[PTR_W-1:0]].id;
         result_we_o    <= tag_mem[tag_rd[PTR_W-1:0]].we;
         result_data_o  <= acc_rsp_data_i;
      end else if (result_ready_i) begin
         result_valid_o <= 1'b0;
      end
   end

   a_rsp_has_tag: assert property (@(posedge clk_i) disable iff (!rst_ni) rsp_hs |-> !tag_empty);

endmodule
